matmul_seq: RTL and testbench

Sequencer for the 8×8 by 8-element matrix-vector multiply datapath. On a host `start`, it reads the A matrix and B vector from a byte-wide memory and loads them into operand registers that drive the datapath. It then launches the multiply, captures the eight results, writes them back to memory as 24-bit words, and reports `done`. A watchdog aborts the job if the datapath never completes.

---
 rtl/matmul_seq.sv | 183 ++++++++++++++++++
 tb/tb_matmul_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq.sv
// Job sequencer for the DIMxDIM by DIM matrix-vector multiply datapath: loads operands from
// byte memory, runs the datapath under a watchdog, and writes the results back.
module matmul_seq #(
    parameter int unsigned DIM     = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned OW      = 24,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       a_base,
    input  logic [ADDR_W-1:0]       b_base,
    input  logic [ADDR_W-1:0]       c_base,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_rd_addr,
    input  logic [DW-1:0]           mem_rd_data,
    output logic                    mem_wr_en,
    output logic [ADDR_W-1:0]       mem_wr_addr,
    output logic [OW-1:0]           mem_wr_data,
    output logic [DIM*DIM*DW-1:0]   mm_a,
    output logic [DIM*DW-1:0]       mm_b,
    output logic                    mm_go,
    input  logic                    mm_done,
    input  logic [DIM*OW-1:0]       mm_c
);

    localparam int NA  = DIM * DIM;
    localparam int NRD = NA + DIM;
    localparam int IW  = $clog2(NRD + 1);
    localparam int CW  = $clog2(TIMEOUT + 1);
    localparam int JW  = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDrain,
        StRun,
        StStore,
        StFin
    } state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       run_cnt_q, run_cnt_d;
    logic                abort_q, abort_d;
    logic [ADDR_W-1:0]   a_base_q, b_base_q, c_base_q;
    logic                pend_q;
    logic [IW-1:0]       pend_idx_q;
    logic [DIM*DIM*DW-1:0] mm_a_q;
    logic [DIM*DW-1:0]   mm_b_q;
    logic [DIM*OW-1:0]   res_q;
    logic                latch_base, latch_res;
    logic [JW-1:0]       wr_sel;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        run_cnt_d  = run_cnt_q;
        abort_d    = abort_q;
        latch_base = 1'b0;
        latch_res  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    latch_base = 1'b1;
                    idx_d      = '0;
                    abort_d    = 1'b0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (idx_q == IW'(NRD - 1)) begin
                    idx_d   = '0;
                    state_d = StDrain;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            StDrain: begin
                run_cnt_d = '0;
                state_d   = StRun;
            end
            StRun: begin
                // A completion in the final watchdog cycle still wins over the abort.
                if (mm_done) begin
                    latch_res = 1'b1;
                    idx_d     = '0;
                    state_d   = StStore;
                end else if (run_cnt_q == CW'(TIMEOUT - 1)) begin
                    abort_d = 1'b1;
                    state_d = StFin;
                end else begin
                    run_cnt_d = run_cnt_q + CW'(1);
                end
            end
            StStore: begin
                if (idx_q == IW'(DIM - 1)) begin
                    state_d = StFin;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            run_cnt_q  <= '0;
            abort_q    <= 1'b0;
            a_base_q   <= '0;
            b_base_q   <= '0;
            c_base_q   <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            run_cnt_q  <= run_cnt_d;
            abort_q    <= abort_d;
            // Read data lands one cycle after issue, so remember which slot it belongs to.
            pend_q     <= (state_q == StLoad);
            pend_idx_q <= idx_q;
            if (latch_base) begin
                a_base_q <= a_base;
                b_base_q <= b_base;
                c_base_q <= c_base;
            end
            if (latch_res) begin
                res_q <= mm_c;
            end
            if (pend_q) begin
                for (int k = 0; k < NA; k++) begin
                    if (pend_idx_q == IW'(k)) begin
                        mm_a_q[k*DW +: DW] <= mem_rd_data;
                    end
                end
                for (int k = 0; k < int'(DIM); k++) begin
                    if (pend_idx_q == IW'(NA + k)) begin
                        mm_b_q[k*DW +: DW] <= mem_rd_data;
                    end
                end
            end
        end
    end

    assign wr_sel = idx_q[JW-1:0];

    always_comb begin
        busy        = (state_q != StIdle);
        done        = (state_q == StFin);
        err         = (state_q == StFin) && abort_q;
        mm_go       = (state_q == StRun);
        mem_rd_en   = (state_q == StLoad);
        mem_wr_en   = (state_q == StStore);
        if (idx_q < IW'(NA)) begin
            mem_rd_addr = a_base_q + ADDR_W'(idx_q);
        end else begin
            mem_rd_addr = b_base_q + ADDR_W'(idx_q - IW'(NA));
        end
        mem_wr_addr = c_base_q + ADDR_W'(idx_q);
        mem_wr_data = res_q[wr_sel*OW +: OW];
    end

    assign mm_a = mm_a_q;
    assign mm_b = mm_b_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq: byte memory, write log and a behavioural datapath with
// programmable latency around one DUT instance (ADDR_W=8, TIMEOUT=16).
module tb_matmul_seq;

    localparam int DIM = 8;
    localparam int DW  = 8;
    localparam int OW  = 24;
    localparam int AW  = 8;
    localparam int TO  = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [AW-1:0]         a_base, b_base, c_base;
    logic                  busy, done, err;
    logic                  mem_rd_en;
    logic [AW-1:0]         mem_rd_addr;
    logic [DW-1:0]         mem_rd_data;
    logic                  mem_wr_en;
    logic [AW-1:0]         mem_wr_addr;
    logic [OW-1:0]         mem_wr_data;
    logic [DIM*DIM*DW-1:0] mm_a;
    logic [DIM*DW-1:0]     mm_b;
    logic                  mm_go;
    logic                  mm_done;
    logic [DIM*OW-1:0]     mm_c;

    matmul_seq #(
        .DIM     (DIM),
        .DW      (DW),
        .OW      (OW),
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a_base      (a_base),
        .b_base      (b_base),
        .c_base      (c_base),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mm_a        (mm_a),
        .mm_b        (mm_b),
        .mm_go       (mm_go),
        .mm_done     (mm_done),
        .mm_c        (mm_c)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:255];
    logic [7:0]  rd_addr_log [0:1023];
    logic [7:0]  wr_addr_log [0:255];
    logic [23:0] wr_data_log [0:255];
    int cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0, go_total = 0;
    int last_done_cyc = -1, dp_cnt = 0;
    int dp_lat = 5;
    logic dp_en = 1'b1, dp_force = 1'b0;
    int n_tests = 0, n_fail = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_rd_addr];
            if (rd_cnt < 1024) rd_addr_log[rd_cnt] <= mem_rd_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (mem_wr_en) begin
            if (wr_cnt < 256) begin
                wr_addr_log[wr_cnt] <= mem_wr_addr;
                wr_data_log[wr_cnt] <= mem_wr_data;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (err) err_cnt <= err_cnt + 1;
        if (mm_go) begin
            go_total <= go_total + 1;
            dp_cnt   <= dp_cnt + 1;
        end else begin
            dp_cnt <= 0;
        end
    end

    // Behavioural datapath: answers dp_lat cycles after mm_go rises.
    assign mm_done = (dp_en && mm_go && (dp_cnt == dp_lat)) || dp_force;
    always_comb begin
        mm_c = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                mm_c[r*OW +: OW] = mm_c[r*OW +: OW]
                    + (24'(mm_a[(r*DIM+c)*DW +: DW]) * 24'(mm_b[c*DW +: DW]));
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic load_nominal(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 64; i++) mem[8'(a + 8'(i))] = 8'(((i / 8) << 4) | (i % 8 + 1));
        for (int j = 0; j < 8; j++) mem[8'(b + 8'(j))] = 8'(8'h81 + j);
    endtask

    task automatic load_sat(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 64; i++) mem[8'(a + 8'(i))] = 8'hFF;
        for (int j = 0; j < 8; j++) mem[8'(b + 8'(j))] = 8'hFF;
    endtask

    task automatic start_job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             output int c0);
        a_base = a;
        b_base = b;
        c_base = c;
        start  = 1'b1;
        c0     = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, 64'({busy, done, err, mem_rd_en, mem_wr_en, mm_go}), 64'd0);
        check({tag, "_addr"}, 64'({mem_rd_addr, mem_wr_addr, mem_wr_data}), 64'd0);
        check({tag, "_ops"}, 64'(|{mm_a, mm_b}), 64'd0);
    endtask

    task automatic check_nominal_writes(input string tag, input int wb, input logic [7:0] cb);
        check({tag, "_wa0"}, 64'(wr_addr_log[wb]), 64'(cb));
        check({tag, "_wd0"}, 64'(wr_data_log[wb]), 64'h0012CC);
        check({tag, "_wa7"}, 64'(wr_addr_log[wb+7]), 64'(8'(cb + 8'd7)));
        check({tag, "_wd7"}, 64'(wr_data_log[wb+7]), 64'h01E28C);
    endtask

    int c0, c1, rb, wb, db, eb, gb;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        a_base = '0;
        b_base = '0;
        c_base = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);

        // Nominal job
        load_nominal(8'h10, 8'h60);
        rb = rd_cnt; wb = wr_cnt; db = done_cnt; gb = go_total;
        start_job(8'h10, 8'h60, 8'h80, c0);
        check("nom_busy_t1", 64'({busy, mem_rd_en}), 64'b11);
        check("nom_rdaddr0", 64'(mem_rd_addr), 64'h10);
        wait_cyc(c0 + 73);
        check("nom_drain", 64'({busy, mem_rd_en, mm_go}), 64'b100);
        check("nom_reads", 64'(rd_cnt - rb), 64'd72);
        check("nom_b_last_addr", 64'(rd_addr_log[rb+71]), 64'h67);
        wait_cyc(c0 + 74);
        check("nom_go_t74", 64'(mm_go), 64'd1);
        check("nom_a00", 64'(mm_a[0 +: 8]), 64'h01);
        check("nom_a77", 64'(mm_a[63*8 +: 8]), 64'h78);
        check("nom_b7", 64'(mm_b[7*8 +: 8]), 64'h88);
        wait_cyc(c0 + 80);
        check("nom_store", 64'({mm_go, mem_wr_en}), 64'b01);
        wait_cyc(c0 + 88);
        check("nom_done", 64'({done, err}), 64'b10);
        wait_cyc(c0 + 89);
        check("nom_idle", 64'(busy), 64'd0);
        check("nom_done_cyc", 64'(last_done_cyc - c0), 64'd88);
        check("nom_writes", 64'(wr_cnt - wb), 64'd8);
        check("nom_go_len", 64'(go_total - gb), 64'd6);
        check("nom_done_cnt", 64'(done_cnt - db), 64'd1);
        check_nominal_writes("nom", wb, 8'h80);

        // Saturation
        load_sat(8'h10, 8'h60);
        wb = wr_cnt;
        start_job(8'h10, 8'h60, 8'h80, c0);
        wait_cyc(c0 + 95);
        check("sat_writes", 64'(wr_cnt - wb), 64'd8);
        for (int j = 0; j < 8; j++) check("sat_wd", 64'(wr_data_log[wb+j]), 64'h07F008);

        // Handshake: stray start and stray mm_done are ignored
        load_nominal(8'h10, 8'h60);
        wb = wr_cnt; db = done_cnt;
        start_job(8'h10, 8'h60, 8'h80, c0);
        wait_cyc(c0 + 10);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_cyc(c0 + 20);
        dp_force = 1'b1; @(negedge clk); dp_force = 1'b0;
        wait_cyc(c0 + 76);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_cyc(c0 + 88);
        check("hs_done", 64'(done), 64'd1);
        start = 1'b1;
        @(negedge clk);
        check("hs_fin_start_ignored", 64'(busy), 64'd0);
        c1 = cyc;
        @(negedge clk);
        start = 1'b0;
        check("hs_second_busy", 64'(busy), 64'd1);
        wait_cyc(c1 + 87);
        check("hs_one_job", 64'(done_cnt - db), 64'd1);
        check("hs_first_done_cyc", 64'(last_done_cyc - c0), 64'd88);
        wait_cyc(c1 + 95);
        check("hs_two_jobs", 64'(done_cnt - db), 64'd2);
        check("hs_second_done_cyc", 64'(last_done_cyc - c1), 64'd88);
        check("hs_writes", 64'(wr_cnt - wb), 64'd16);
        check_nominal_writes("hs1", wb, 8'h80);
        check_nominal_writes("hs2", wb + 8, 8'h80);

        // Reset mid-LOAD at i=30
        rb = rd_cnt; wb = wr_cnt; db = done_cnt;
        start_job(8'h10, 8'h60, 8'h80, c0);
        wait_cyc(c0 + 31);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("rst_load");
        check("rst_load_reads", 64'(rd_cnt - rb), 64'd31);
        rst = 1'b0;
        rb = rd_cnt;
        repeat (100) @(negedge clk);
        check("rst_load_traffic", 64'({rd_cnt - rb, wr_cnt - wb, done_cnt - db}), 64'd0);

        // Reset mid-STORE at j=3
        wb = wr_cnt; db = done_cnt;
        start_job(8'h10, 8'h60, 8'h80, c0);
        wait_cyc(c0 + 83);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("rst_store");
        check("rst_store_writes", 64'(wr_cnt - wb), 64'd4);
        rst = 1'b0;
        wb = wr_cnt;
        repeat (30) @(negedge clk);
        check("rst_store_traffic", 64'({wr_cnt - wb, done_cnt - db}), 64'd0);

        // Fresh job after reset
        wb = wr_cnt;
        start_job(8'h10, 8'h60, 8'h80, c0);
        wait_cyc(c0 + 95);
        check("fresh_done_cyc", 64'(last_done_cyc - c0), 64'd88);
        check_nominal_writes("fresh", wb, 8'h80);

        // Timeout: datapath silent
        dp_en = 1'b0;
        wb = wr_cnt; db = done_cnt; eb = err_cnt; gb = go_total;
        start_job(8'h10, 8'h60, 8'h80, c0);
        wait_cyc(c0 + 90);
        check("to_fin", 64'({done, err, mm_go}), 64'b110);
        wait_cyc(c0 + 100);
        check("to_go_len", 64'(go_total - gb), 64'd16);
        check("to_writes", 64'(wr_cnt - wb), 64'd0);
        check("to_done_err", 64'({done_cnt - db, err_cnt - eb}), 64'({32'd1, 32'd1}));
        dp_en = 1'b1;

        // mm_done in the last watchdog cycle counts as success
        dp_lat = 15;
        wb = wr_cnt; eb = err_cnt; gb = go_total;
        start_job(8'h10, 8'h60, 8'h80, c0);
        wait_cyc(c0 + 105);
        check("edge_done_cyc", 64'(last_done_cyc - c0), 64'd98);
        check("edge_no_err", 64'(err_cnt - eb), 64'd0);
        check("edge_go_len", 64'(go_total - gb), 64'd16);
        check_nominal_writes("edge", wb, 8'h80);
        dp_lat = 5;

        // Address wrap
        load_nominal(8'hF0, 8'h40);
        rb = rd_cnt; wb = wr_cnt;
        start_job(8'hF0, 8'h40, 8'hFC, c0);
        wait_cyc(c0 + 95);
        check("wrap_rd15", 64'(rd_addr_log[rb+15]), 64'hFF);
        check("wrap_rd16", 64'(rd_addr_log[rb+16]), 64'h00);
        check("wrap_rd63", 64'(rd_addr_log[rb+63]), 64'h2F);
        check("wrap_rd64", 64'(rd_addr_log[rb+64]), 64'h40);
        check("wrap_wa3", 64'(wr_addr_log[wb+3]), 64'hFF);
        check("wrap_wa4", 64'(wr_addr_log[wb+4]), 64'h00);
        check_nominal_writes("wrap", wb, 8'hFC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
